mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Shares the single CPU memory bus between up to four requesters: instruction fetch (0), load/store (1), AMO unit (2), and the external/DMA port (3). It latches one request, issues it on the bus, waits for i_bus_DV, then returns read data and a one-cycle done pulse to the winner. It supports a lock for atomic read-modify-write sequences and a watchdog timeout, so a dead slave cannot hang the control unit.

Parameters:
N_REQ, 4, number of requesters; index 0 has highest fixed priority
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT_CYCLES, 1023, max cycles in WAIT before aborting; 0 disables the watchdog

Ports:
i_clk  in  1  clock; all logic on the rising edge
i_rst  in  1  asynchronous, active-high reset
i_req  in  N_REQ  request per requester; held high until the matching o_dv
i_we  in  N_REQ  1 = write, 0 = read; sampled at grant
i_lock  in  N_REQ  keep the grant after completion (AMO read→write)
i_addr  in  N_REQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W]
i_wdata  in  N_REQ*DATA_W  packed write data
o_gnt  out  N_REQ  one-hot current owner, registered
o_dv  out  N_REQ  one-cycle completion pulse to the owner
o_err  out  1  one-cycle pulse coincident with o_dv when aborted by timeout
o_rdata  out  DATA_W  read data; valid in the o_dv cycle and held until the next completion
o_bus_req  out  1  one-cycle bus start pulse
o_bus_we  out  1  bus write enable, held for the whole transaction
o_bus_addr  out  ADDR_W  latched address
o_bus_wdata  out  DATA_W  latched write data
i_bus_DV  in  1  bus completion (read data valid / write acked)
i_bus_rdata  in  DATA_W  bus read data
o_busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE; o_gnt, o_dv, o_err, o_bus_req, o_bus_we, o_busy = 0; o_rdata, o_bus_addr, o_bus_wdata = 0; timeout counter = 0; lock owner cleared.
- All outputs are registered.
- IDLE: if any i_req is set, pick the winner k (lowest index without the optional feature). Latch i_addr[k], i_wdata[k], i_we[k]. Set o_gnt=1<<k and o_bus_req=1, then go to ISSUE.
- ISSUE lasts 1 cycle. o_bus_req drops, and the counter clears. Go to WAIT. i_bus_DV is ignored in ISSUE; the bus guarantees DV comes at least one cycle after the request.
- WAIT, on i_bus_DV: o_rdata←i_bus_rdata (reads only; writes leave it unchanged), pulse o_dv[k].
  - If i_lock[k]=0: clear o_gnt and go to IDLE.
  - If i_lock[k]=1: keep o_gnt and go to LOCKED.
- WAIT, no DV: the counter increments. When counter == TIMEOUT_CYCLES-1 (and TIMEOUT_CYCLES != 0): pulse o_dv[k] and o_err, set o_rdata=0, clear o_gnt and the lock, go to IDLE. If DV and timeout occur in the same cycle, DV wins and o_err=0.
- LOCKED: only requester k may be serviced. When i_req[k]=1, latch its request, pulse o_bus_req, go to ISSUE. If i_lock[k] drops while i_req[k]=0, clear o_gnt and go to IDLE. Other requesters stall.
- Latency: request seen at edge T → o_gnt/o_bus_req at T+1. DV sampled at edge D → o_dv at D+1.
  - IDLE re-arbitrates in the o_dv cycle, so the next grant appears at D+2.
  - Minimum occupancy is 3 cycles per transaction.
- Requester rules:
  - Deasserting i_req mid-transaction does not abort; o_dv is still delivered.
  - A requester must drop i_req in the cycle after its o_dv, or it re-requests.
  - A late i_bus_DV seen in IDLE/LOCKED is ignored.
- o_gnt is always one-hot or zero. Exactly one o_dv bit pulses per transaction.

Optional Feature:
MEM_ARB_ROUND_ROBIN_EN. When defined, IDLE arbitration is round-robin: search starts at (last_winner+1) mod N_REQ, and the pointer resets to N_REQ-1 so index 0 wins first after reset. The pointer updates on every grant from IDLE, not on LOCKED re-issues. When undefined, fixed priority applies (index 0 highest) and no pointer register exists.

Test Plan:
1. Single read: i_req=0010, addr 0x100, bus DV 3 cycles after o_bus_req with rdata 0xDEADBEEF → o_gnt=0010 at T+1, one-cycle o_bus_req with addr 0x100 and we=0, o_dv=0010 with o_rdata=0xDEADBEEF, o_err=0.
2. Contention: i_req=1011 all held. Fixed priority → grants 0,0,0… (starves 1, 3). With MEM_ARB_ROUND_ROBIN_EN → order 0,1,3,0.
3. AMO lock: req2 read with i_lock[2]=1, then write 0x5. Meanwhile i_req[0]=1 → req0 is not granted until lock drops. The bus sees read then write, both addr 0x200, with no intervening transaction.
4. Timeout: TIMEOUT_CYCLES=8, DV never asserted → o_dv and o_err pulse 8 cycles after entering WAIT, o_rdata=0, arbiter returns to IDLE and serves the next request. A DV arriving on the 8th cycle → o_err=0 with normal data.
5. Reset mid-WAIT: assert i_rst asynchronously → o_gnt, o_busy, o_bus_req go to 0 immediately. After release, a fresh request completes normally, and a stale DV in IDLE produces no o_dv.
6. Write: i_req=1000, we=1, wdata 0x12345678 → o_bus_we=1 and o_bus_wdata=0x12345678 held until DV. o_rdata is unchanged from its previous value.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one CPU memory bus between N_REQ requesters.
// Latches one request, issues it on the bus, waits for i_bus_DV (or a watchdog
// timeout) and returns read data plus a one-cycle done pulse to the owner.
// A requester holding i_lock keeps the grant across transactions (AMO RMW).
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// in IDLE; when undefined, index 0 has fixed highest priority.
module mem_bus_arbiter #(
   parameter int unsigned N_REQ          = 4,
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [N_REQ-1:0]          i_req,
   input  logic [N_REQ-1:0]          i_we,
   input  logic [N_REQ-1:0]          i_lock,
   input  logic [N_REQ*ADDR_W-1:0]   i_addr,
   input  logic [N_REQ*DATA_W-1:0]   i_wdata,
   output logic [N_REQ-1:0]          o_gnt,
   output logic [N_REQ-1:0]          o_dv,
   output logic                      o_err,
   output logic [DATA_W-1:0]         o_rdata,
   output logic                      o_bus_req,
   output logic                      o_bus_we,
   output logic [ADDR_W-1:0]         o_bus_addr,
   output logic [DATA_W-1:0]         o_bus_wdata,
   input  logic                      i_bus_DV,
   input  logic [DATA_W-1:0]         i_bus_rdata,
   output logic                      o_busy
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ISSUE  = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_LOCKED = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [N_REQ-1:0]  dv_q, dv_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
   logic              busy_q, busy_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;

   logic [IDX_W-1:0]  win_idx;
   logic              win_any;
   logic [IDX_W-1:0]  sel_idx;
   logic              timeout_hit;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   int                rr_j;

   // Round-robin pick: walk from lowest to highest priority so the last hit wins.
   always_comb begin
      win_idx = '0;
      win_any = 1'b0;
      rr_j    = 0;
      for (int i = int'(N_REQ); i >= 1; i--) begin
         rr_j = (int'(ptr_q) + i) % int'(N_REQ);
         if (i_req[rr_j]) begin
            win_idx = IDX_W'(rr_j);
            win_any = 1'b1;
         end
      end
   end
`else
   // Fixed priority pick: lowest index wins.
   always_comb begin
      win_idx = '0;
      win_any = 1'b0;
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            win_idx = IDX_W'(i);
            win_any = 1'b1;
         end
      end
   end
`endif

   // In LOCKED only the lock owner may be latched; otherwise the arbitration winner.
   assign sel_idx     = (state_q == ST_LOCKED) ? idx_q : win_idx;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

   // Next-state and output-register logic for the transaction FSM.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      dv_d        = '0;
      err_d       = 1'b0;
      rdata_d     = rdata_q;
      bus_req_d   = 1'b0;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_d       = ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (win_any) begin
               idx_d       = win_idx;
               gnt_d       = N_REQ'(1) << win_idx;
               bus_we_d    = i_we[sel_idx];
               bus_addr_d  = i_addr[sel_idx*ADDR_W +: ADDR_W];
               bus_wdata_d = i_wdata[sel_idx*DATA_W +: DATA_W];
               bus_req_d   = 1'b1;
               state_d     = ST_ISSUE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
               ptr_d       = win_idx;
`endif
            end
         end
         ST_ISSUE: begin
            // DV cannot arrive in this cycle, so it is not looked at here.
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (i_bus_DV) begin
               if (!bus_we_q) begin
                  rdata_d = i_bus_rdata;
               end
               dv_d = gnt_q;
               if (i_lock[idx_q]) begin
                  state_d = ST_LOCKED;
               end else begin
                  gnt_d   = '0;
                  state_d = ST_IDLE;
               end
            end else if (timeout_hit) begin
               dv_d    = gnt_q;
               err_d   = 1'b1;
               rdata_d = '0;
               gnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_LOCKED: begin
            if (i_req[idx_q]) begin
               bus_we_d    = i_we[sel_idx];
               bus_addr_d  = i_addr[sel_idx*ADDR_W +: ADDR_W];
               bus_wdata_d = i_wdata[sel_idx*DATA_W +: DATA_W];
               bus_req_d   = 1'b1;
               state_d     = ST_ISSUE;
            end else if (!i_lock[idx_q]) begin
               gnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         gnt_q       <= '0;
         dv_q        <= '0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         busy_q      <= 1'b0;
         cnt_q       <= '0;
         idx_q       <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         ptr_q       <= IDX_W'(N_REQ - 1);
`endif
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         dv_q        <= dv_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         busy_q      <= busy_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         ptr_q       <= ptr_d;
`endif
      end
   end

   assign o_gnt       = gnt_q;
   assign o_dv        = dv_q;
   assign o_err       = err_q;
   assign o_rdata     = rdata_q;
   assign o_bus_req   = bus_req_q;
   assign o_bus_we    = bus_we_q;
   assign o_bus_addr  = bus_addr_q;
   assign o_bus_wdata = bus_wdata_q;
   assign o_busy      = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed bench for mem_bus_arbiter with a completion
// scoreboard. Expected completions are queued when the bus reply is driven and
// compared when o_dv pulses.
module tb_mem_bus_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   typedef struct packed {
      logic [3:0]  dv;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    req = '0;
   logic [3:0]    we = '0;
   logic [3:0]    lock = '0;
   logic [127:0]  addr = '0;
   logic [127:0]  wdata = '0;
   logic [3:0]    gnt;
   logic [3:0]    dv;
   logic          err;
   logic [31:0]   rdata;
   logic          bus_req;
   logic          bus_we;
   logic [31:0]   bus_addr;
   logic [31:0]   bus_wdata;
   logic          bus_dv = 1'b0;
   logic [31:0]   bus_rdata = '0;
   logic          busy;

   int   vectors = 0;
   int   fails = 0;
   exp_t sb[$];
   int   order[4];

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_lock(lock),
      .i_addr(addr), .i_wdata(wdata), .o_gnt(gnt), .o_dv(dv), .o_err(err),
      .o_rdata(rdata), .o_bus_req(bus_req), .o_bus_we(bus_we),
      .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata), .i_bus_DV(bus_dv),
      .i_bus_rdata(bus_rdata), .o_busy(busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_bus_req(input string tag);
      int n = 0;
      while (bus_req !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check({tag, ".bus_req"}, 64'(bus_req), 64'd1);
   endtask

   task automatic do_bus(input int lat, input logic [31:0] data);
      repeat (lat - 1) tick();
      bus_dv    = 1'b1;
      bus_rdata = data;
      tick();
      bus_dv    = 1'b0;
      bus_rdata = '0;
   endtask

   task automatic push(input logic [3:0] d, input logic [31:0] r, input logic e);
      exp_t x;
      x.dv    = d;
      x.rdata = r;
      x.err   = e;
      sb.push_back(x);
   endtask

   task automatic check_done(input string tag);
      exp_t x;
      if (sb.size() == 0) begin
         check({tag, ".sb_nonempty"}, 64'(0), 64'(1));
      end else begin
         x = sb.pop_front();
         check({tag, ".dv"}, 64'(dv), 64'(x.dv));
         check({tag, ".rdata"}, 64'(rdata), 64'(x.rdata));
         check({tag, ".err"}, 64'(err), 64'(x.err));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      order = '{0, 1, 3, 0};
`else
      order = '{0, 0, 0, 0};
`endif
      // Reset state
      tick();
      tick();
      check("rst.gnt", 64'(gnt), 64'd0);
      check("rst.dv", 64'(dv), 64'd0);
      check("rst.bus_req", 64'(bus_req), 64'd0);
      check("rst.busy", 64'(busy), 64'd0);
      check("rst.rdata", 64'(rdata), 64'd0);
      rst = 1'b0;
      tick();

      // Contention: 0, 1 and 3 all held
      for (int k = 0; k < 4; k++) addr[k*32 +: 32] = 32'h10 * (k + 1);
      req = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         wait_bus_req("cont");
         check("cont.gnt", 64'(gnt), 64'(4'b1 << order[i]));
         check("cont.addr", 64'(bus_addr), 64'(32'h10 * (order[i] + 1)));
         push(4'b1 << order[i], 32'hA0 + i, 1'b0);
         do_bus(2, 32'hA0 + i);
         check_done("cont");
         if (i == 3) begin
            req = '0;
         end else begin
            tick();
            check("cont.regrant", 64'(bus_req), 64'd1);
            check("cont.dv_one", 64'(dv), 64'd0);
         end
      end
      tick();
      check("cont.idle", 64'(busy), 64'd0);

      // Single read
      addr[1*32 +: 32] = 32'h100;
      req = 4'b0010;
      wait_bus_req("rd");
      check("rd.gnt", 64'(gnt), 64'b0010);
      check("rd.addr", 64'(bus_addr), 64'h100);
      check("rd.we", 64'(bus_we), 64'd0);
      check("rd.busy", 64'(busy), 64'd1);
      tick();
      check("rd.req_pulse", 64'(bus_req), 64'd0);
      push(4'b0010, 32'hDEADBEEF, 1'b0);
      do_bus(2, 32'hDEADBEEF);
      check_done("rd");
      req = '0;
      check("rd.gnt_clr", 64'(gnt), 64'd0);
      check("rd.busy_clr", 64'(busy), 64'd0);
      tick();

      // Write leaves o_rdata unchanged
      addr[3*32 +: 32]  = 32'h180;
      wdata[3*32 +: 32] = 32'h12345678;
      we  = 4'b1000;
      req = 4'b1000;
      wait_bus_req("wr");
      check("wr.gnt", 64'(gnt), 64'b1000);
      check("wr.we", 64'(bus_we), 64'd1);
      check("wr.wdata", 64'(bus_wdata), 64'h12345678);
      push(4'b1000, 32'hDEADBEEF, 1'b0);
      tick();
      check("wr.we_held", 64'(bus_we), 64'd1);
      check("wr.wdata_held", 64'(bus_wdata), 64'h12345678);
      do_bus(2, 32'hFFFF0000);
      check_done("wr");
      req = '0;
      we  = '0;
      tick();

      // AMO lock: req0 must wait until the RMW pair is done
      addr[2*32 +: 32] = 32'h200;
      addr[0*32 +: 32] = 32'h300;
      lock = 4'b0100;
      req  = 4'b0100;
      wait_bus_req("amo.rd");
      check("amo.rd.gnt", 64'(gnt), 64'b0100);
      check("amo.rd.addr", 64'(bus_addr), 64'h200);
      req[0] = 1'b1;
      push(4'b0100, 32'h77, 1'b0);
      do_bus(2, 32'h77);
      check_done("amo.rd");
      we[2] = 1'b1;
      wdata[2*32 +: 32] = 32'h5;
      tick();
      check("amo.wr.bus_req", 64'(bus_req), 64'd1);
      check("amo.wr.gnt", 64'(gnt), 64'b0100);
      check("amo.wr.addr", 64'(bus_addr), 64'h200);
      check("amo.wr.we", 64'(bus_we), 64'd1);
      check("amo.wr.wdata", 64'(bus_wdata), 64'h5);
      lock = '0;
      push(4'b0100, 32'h77, 1'b0);
      do_bus(2, 32'hBAD);
      check_done("amo.wr");
      req[2] = 1'b0;
      we[2]  = 1'b0;
      tick();
      check("amo.next.bus_req", 64'(bus_req), 64'd1);
      check("amo.next.gnt", 64'(gnt), 64'b0001);
      check("amo.next.addr", 64'(bus_addr), 64'h300);
      push(4'b0001, 32'h1111, 1'b0);
      do_bus(2, 32'h1111);
      check_done("amo.next");
      req = '0;
      tick();

      // Timeout, then a DV on the last allowed WAIT cycle
      addr[1*32 +: 32] = 32'h400;
      req = 4'b0010;
      wait_bus_req("to");
      check("to.gnt", 64'(gnt), 64'b0010);
      addr[3*32 +: 32] = 32'h480;
      req[3] = 1'b1;
      repeat (8) tick();
      check("to.early_dv", 64'(dv), 64'd0);
      check("to.busy", 64'(busy), 64'd1);
      tick();
      push(4'b0010, 32'h0, 1'b1);
      check_done("to");
      check("to.gnt_clr", 64'(gnt), 64'd0);
      req[1] = 1'b0;
      tick();
      check("to.next.bus_req", 64'(bus_req), 64'd1);
      check("to.next.gnt", 64'(gnt), 64'b1000);
      push(4'b1000, 32'hCAFE0008, 1'b0);
      do_bus(9, 32'hCAFE0008);
      check_done("to.late_dv");
      req = '0;
      tick();

      // Asynchronous reset in WAIT, stale DV, then a fresh transaction
      addr[0*32 +: 32] = 32'h500;
      req = 4'b0001;
      wait_bus_req("ar");
      tick();
      #2 rst = 1'b1;
      #1;
      check("ar.gnt", 64'(gnt), 64'd0);
      check("ar.busy", 64'(busy), 64'd0);
      check("ar.bus_req", 64'(bus_req), 64'd0);
      check("ar.bus_addr", 64'(bus_addr), 64'd0);
      req = '0;
      tick();
      rst = 1'b0;
      bus_dv = 1'b1;
      bus_rdata = 32'h999;
      tick();
      bus_dv = 1'b0;
      check("ar.stale_dv", 64'(dv), 64'd0);
      check("ar.stale_busy", 64'(busy), 64'd0);
      check("ar.stale_rdata", 64'(rdata), 64'd0);
      req = 4'b0001;
      wait_bus_req("ar.fresh");
      check("ar.fresh.gnt", 64'(gnt), 64'b0001);
      push(4'b0001, 32'h55AA, 1'b0);
      do_bus(3, 32'h55AA);
      check_done("ar.fresh");
      req = '0;
      tick();
      check("ar.dv_one", 64'(dv), 64'd0);
      check("sb.drained", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
